reg_dump_reader: RTL and testbench

//  Sequential reader for the 2**A_WIDTH x D_WIDTH CPU register file: on START, scans every register through one

---
 rtl/reg_dump_reader.sv | 118 +++++++++++
 tb/tb_reg_dump_reader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// Scans every register of the CPU register file through one spare read port and
// streams {index, value} words to a debug/trace consumer over valid/ready.
module reg_dump_reader #(
   parameter int A_WIDTH = 5,
   parameter int D_WIDTH = 32,
   parameter bit SKIP_X0 = 1'b1
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               START,
   input  logic               ABORT,
   output logic [A_WIDTH-1:0] RA,
   input  logic [D_WIDTH-1:0] RD,
   output logic               OUT_VALID,
   input  logic               OUT_READY,
   output logic [A_WIDTH-1:0] OUT_ADDR,
   output logic [D_WIDTH-1:0] OUT_DATA,
   output logic               OUT_LAST,
   output logic               BUSY,
   output logic               DONE
);

   localparam logic [A_WIDTH-1:0] FIRST_IDX = SKIP_X0 ? A_WIDTH'(1) : '0;
   localparam logic [A_WIDTH-1:0] LAST_IDX  = '1;

   typedef enum logic [1:0] {IDLE, READ, HOLD, FIN} state_t;

   state_t             state, state_nxt;
   logic [A_WIDTH-1:0] idx, idx_nxt;
   logic               ld_word;
   logic               ack_word;
   logic               clr_word;

   function automatic logic is_last(input logic [A_WIDTH-1:0] i);
      return i == LAST_IDX;
   endfunction

   always_ff @(posedge CLK) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;
   end

   // ABORT outranks the handshake in every non-IDLE state.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      ld_word   = 1'b0;
      ack_word  = 1'b0;
      clr_word  = 1'b0;
      case (state)
         IDLE: begin
            if (START) begin
               idx_nxt   = FIRST_IDX;
               state_nxt = READ;
            end
         end
         READ: begin
            if (ABORT) begin
               clr_word  = 1'b1;
               state_nxt = IDLE;
            end else begin
               ld_word   = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (ABORT) begin
               clr_word  = 1'b1;
               state_nxt = IDLE;
            end else if (OUT_READY) begin
               ack_word = 1'b1;
               if (OUT_LAST) begin
                  state_nxt = FIN;
               end else begin
                  idx_nxt   = idx + A_WIDTH'(1);
                  state_nxt = READ;
               end
            end
         end
         FIN: begin
            clr_word  = ABORT;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // idx is itself the registered read address, so RA is stable through READ.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         idx       <= '0;
         OUT_VALID <= 1'b0;
         OUT_ADDR  <= '0;
         OUT_DATA  <= '0;
         OUT_LAST  <= 1'b0;
      end else begin
         idx <= idx_nxt;
         if (ld_word) begin
            OUT_DATA  <= RD;
            OUT_ADDR  <= idx;
            OUT_LAST  <= is_last(idx);
            OUT_VALID <= 1'b1;
         end
         if (ack_word) begin
            OUT_VALID <= 1'b0;
         end
         if (clr_word) begin
            OUT_VALID <= 1'b0;
            OUT_LAST  <= 1'b0;
         end
      end
   end

   assign RA   = idx;
   assign BUSY = (state != IDLE);
   assign DONE = (state == FIN);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: a register-file model feeds two instances
// (SKIP_X0=1 and SKIP_X0=0); every accepted word is checked against the expected stream.
module tb_reg_dump_reader;

   logic        CLK;
   logic        RST_N;
   logic        START0, START1, ABORT0;
   logic        READY;
   logic [4:0]  RA0, RA1;
   logic [31:0] RD0, RD1;
   logic        OUT_VALID0, OUT_VALID1, OUT_LAST0, OUT_LAST1;
   logic [4:0]  OUT_ADDR0, OUT_ADDR1;
   logic [31:0] OUT_DATA0, OUT_DATA1;
   logic        BUSY0, BUSY1, DONE0, DONE1;

   logic        WE;
   logic [4:0]  WA;
   logic [31:0] WD;
   logic [31:0] rf [32];

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          rdy_mode = 0;
   logic [3:0]  pat = 4'b1001;
   logic        inv_en = 1'b0;

   logic [31:0] exp_data [32];
   int          exp0 = 0, exp1 = 0, wcnt0 = 0, wcnt1 = 0;
   logic [4:0]  fw0;
   logic [31:0] w5;

   reg_dump_reader #(.A_WIDTH(5), .D_WIDTH(32), .SKIP_X0(1'b1)) dut0 (
      .CLK(CLK), .RST_N(RST_N), .START(START0), .ABORT(ABORT0),
      .RA(RA0), .RD(RD0), .OUT_VALID(OUT_VALID0), .OUT_READY(READY),
      .OUT_ADDR(OUT_ADDR0), .OUT_DATA(OUT_DATA0), .OUT_LAST(OUT_LAST0),
      .BUSY(BUSY0), .DONE(DONE0));

   reg_dump_reader #(.A_WIDTH(5), .D_WIDTH(32), .SKIP_X0(1'b0)) dut1 (
      .CLK(CLK), .RST_N(RST_N), .START(START1), .ABORT(1'b0),
      .RA(RA1), .RD(RD1), .OUT_VALID(OUT_VALID1), .OUT_READY(READY),
      .OUT_ADDR(OUT_ADDR1), .OUT_DATA(OUT_DATA1), .OUT_LAST(OUT_LAST1),
      .BUSY(BUSY1), .DONE(DONE1));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Register file: x0 reads as zero, writes land on the clock edge.
   always @(posedge CLK) if (WE) rf[WA] <= WD;
   assign RD0 = (RA0 == 5'd0) ? 32'd0 : rf[RA0];
   assign RD1 = (RA1 == 5'd0) ? 32'd0 : rf[RA1];

   function automatic logic [31:0] word_val(input int a);
      logic [4:0] i;
      i = a[4:0];
      return (a == 0) ? 32'd0 : exp_data[i];
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // One clock: score words accepted at the coming edge, then check stalls and invariants.
   task automatic tick();
      logic        hs0, st0, hs1;
      logic [4:0]  sa;
      logic [31:0] sd;
      logic        sl, sv;
      hs0 = RST_N && OUT_VALID0 && READY && !ABORT0;
      st0 = RST_N && OUT_VALID0 && !READY && !ABORT0;
      hs1 = RST_N && OUT_VALID1 && READY;
      sa = OUT_ADDR0; sd = OUT_DATA0; sl = OUT_LAST0; sv = OUT_VALID0;
      if (RST_N && START0 && !BUSY0) begin exp0 = 1; wcnt0 = 0; end
      if (RST_N && START1 && !BUSY1) begin exp1 = 0; wcnt1 = 0; end
      if (hs0 === 1'b1) begin
         chk("word_addr", 64'(sa), 64'(exp0));
         chk("word_data", 64'(sd), 64'(word_val(exp0)));
         chk("word_last", 64'(sl), 64'(exp0 == 31));
         if (wcnt0 == 0) fw0 = sa;
         if (exp0 == 5) w5 = sd;
         exp0++; wcnt0++;
      end
      if (hs1 === 1'b1) begin
         chk("word1_addr", 64'(OUT_ADDR1), 64'(exp1));
         chk("word1_data", 64'(OUT_DATA1), 64'(word_val(exp1)));
         chk("word1_last", 64'(OUT_LAST1), 64'(exp1 == 31));
         exp1++; wcnt1++;
      end
      @(posedge CLK); #1;
      if (st0 === 1'b1) begin
         chk("stall_addr", 64'(OUT_ADDR0), 64'(sa));
         chk("stall_data", 64'(OUT_DATA0), 64'(sd));
         chk("stall_last", 64'(OUT_LAST0), 64'(sl));
         chk("stall_valid", 64'(OUT_VALID0), 64'(sv));
      end
      if (inv_en && RST_N) begin
         chk("inv_done_novalid", 64'(DONE0 & OUT_VALID0), 64'd0);
         chk("inv_valid_busy", 64'(OUT_VALID0 & !BUSY0), 64'd0);
      end
      cyc++;
      READY = (rdy_mode == 1) ? pat[cyc % 4] : 1'b1;
   endtask

   // Runs one dump on dut0; wr_at/ab_at/st_at name the edge (START edge = 0)
   // at which a core write, an ABORT or a stray START is applied.
   task automatic run0(input int wr_at, input int ab_at, input int st_at, output int n);
      n = 0;
      START0 = 1'b1;
      tick();
      START0 = 1'b0;
      while (!DONE0 && n < 400 && !(ab_at > 0 && n >= ab_at)) begin
         WE     = (n + 1 == wr_at);
         ABORT0 = (n + 1 == ab_at);
         START0 = (n + 1 == st_at);
         tick();
         n++;
      end
      WE = 1'b0; ABORT0 = 1'b0; START0 = 1'b0;
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_ra"},    64'(RA0), 64'd0);
      chk({nm, "_addr"},  64'(OUT_ADDR0), 64'd0);
      chk({nm, "_data"},  64'(OUT_DATA0), 64'd0);
      chk({nm, "_valid"}, 64'(OUT_VALID0), 64'd0);
      chk({nm, "_last"},  64'(OUT_LAST0), 64'd0);
      chk({nm, "_busy"},  64'(BUSY0), 64'd0);
      chk({nm, "_done"},  64'(DONE0), 64'd0);
   endtask

   initial begin
      int n;
      RST_N = 1'b0; START0 = 1'b0; START1 = 1'b0; ABORT0 = 1'b0;
      WE = 1'b0; WA = '0; WD = '0; READY = 1'b1;
      for (int i = 0; i < 32; i++) exp_data[i] = 32'hA000_0000 + i;
      tick(); tick();
      chk_all_zero("reset");
      RST_N = 1'b1;
      inv_en = 1'b1;
      for (int i = 0; i < 32; i++) begin
         WE = 1'b1; WA = 5'(i); WD = 32'hA000_0000 + i;
         tick();
      end
      WE = 1'b0;
      tick();

      // Full dump, READY high; ABORT together with START in IDLE is ignored.
      START0 = 1'b1; ABORT0 = 1'b1;
      tick();
      START0 = 1'b0; ABORT0 = 1'b0;
      chk("t1_busy", 64'(BUSY0), 64'd1);
      chk("t1_valid_lat1", 64'(OUT_VALID0), 64'd0);
      chk("t1_ra_read", 64'(RA0), 64'd1);
      tick();
      n = 1;
      chk("t1_valid_lat2", 64'(OUT_VALID0), 64'd1);
      chk("t1_first_addr", 64'(OUT_ADDR0), 64'd1);
      chk("t1_first_data", 64'(OUT_DATA0), 64'hA000_0001);
      chk("t1_first_last", 64'(OUT_LAST0), 64'd0);
      while (!DONE0 && n < 400) begin tick(); n++; end
      chk("t1_done_edge", 64'(n), 64'd62);
      chk("t1_words", 64'(wcnt0), 64'd31);
      chk("t1_final_addr", 64'(OUT_ADDR0), 64'd31);
      chk("t1_final_data", 64'(OUT_DATA0), 64'hA000_001F);
      chk("t1_busy_fin", 64'(BUSY0), 64'd1);
      tick();
      chk("t1_done_pulse", 64'(DONE0), 64'd0);
      chk("t1_idle_busy", 64'(BUSY0), 64'd0);

      // READY pattern 1,0,0,1: stream must match the unstalled one.
      rdy_mode = 1;
      run0(0, 0, 0, n);
      rdy_mode = 0;
      READY = 1'b1;
      chk("t2_done_reached", 64'(n < 400), 64'd1);
      chk("t2_words", 64'(wcnt0), 64'd31);
      chk("t2_first_addr", 64'(fw0), 64'd1);
      tick();

      // SKIP_X0=0 starts at x0.
      START1 = 1'b1;
      tick();
      START1 = 1'b0;
      tick();
      n = 1;
      chk("t3_first_valid", 64'(OUT_VALID1), 64'd1);
      chk("t3_first_addr", 64'(OUT_ADDR1), 64'd0);
      chk("t3_first_data", 64'(OUT_DATA1), 64'd0);
      while (!DONE1 && n < 400) begin tick(); n++; end
      chk("t3_done_edge", 64'(n), 64'd64);
      chk("t3_words", 64'(wcnt1), 64'd32);
      tick();

      // Core write to x5 on the capture edge of word 5: old value is streamed.
      exp_data[5] = 32'hA000_0005;
      WA = 5'd5; WD = 32'hDEAD_BEEF;
      run0(9, 0, 0, n);
      chk("t4_same_edge_w5", 64'(w5), 64'hA000_0005);
      chk("t4_same_edge_done", 64'(n), 64'd62);
      WE = 1'b1; WA = 5'd5; WD = 32'hA000_0005; tick(); WE = 1'b0;
      // One edge earlier: new value is streamed.
      exp_data[5] = 32'hDEAD_BEEF;
      WA = 5'd5; WD = 32'hDEAD_BEEF;
      run0(8, 0, 0, n);
      chk("t4_early_w5", 64'(w5), 64'hDEAD_BEEF);
      WE = 1'b1; WA = 5'd5; WD = 32'hA000_0005; tick(); WE = 1'b0;
      exp_data[5] = 32'hA000_0005;
      tick();

      // ABORT while word 7 is offered with READY high.
      run0(0, 14, 0, n);
      chk("t5_abort_edge", 64'(n), 64'd14);
      chk("t5_valid", 64'(OUT_VALID0), 64'd0);
      chk("t5_busy", 64'(BUSY0), 64'd0);
      chk("t5_done", 64'(DONE0), 64'd0);
      chk("t5_last", 64'(OUT_LAST0), 64'd0);
      chk("t5_words", 64'(wcnt0), 64'd6);
      tick();
      chk("t5_no_done", 64'(DONE0), 64'd0);
      run0(0, 0, 0, n);
      chk("t5_restart_addr", 64'(fw0), 64'd1);
      chk("t5_restart_words", 64'(wcnt0), 64'd31);
      tick();

      // Reset at word 12, then a full dump with a stray START mid-run.
      START0 = 1'b1;
      tick();
      START0 = 1'b0;
      n = 0;
      while (!(OUT_VALID0 && OUT_ADDR0 == 5'd12) && n < 100) begin tick(); n++; end
      chk("t6_reach_12", 64'(OUT_ADDR0), 64'd12);
      RST_N = 1'b0; START0 = 1'b1;
      tick();
      chk_all_zero("t6_reset");
      RST_N = 1'b1; START0 = 1'b0;
      tick();
      chk("t6_idle_after_rst", 64'(BUSY0), 64'd0);
      run0(0, 0, 5, n);
      chk("t6_done_edge", 64'(n), 64'd62);
      chk("t6_words", 64'(wcnt0), 64'd31);
      chk("t6_first_addr", 64'(fw0), 64'd1);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
